// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with a valid/ready handshake
// and a 2-entry skid buffer (main + skid).
//
// The main entry drives the outputs. When downstream stalls, the skid entry
// absorbs one extra item, so in_ready can come straight from a flop.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous squash of all held entries
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   in_data/reg/ctrl    incoming payload (data word 0 in LSBs)
//   out_valid/out_ready downstream handshake
//   out_data/reg/ctrl   registered payload; out_ctrl forced to 0 on a bubble
//   cnt_clr             synchronous clear of the bubble counter
//   bubble_cnt          saturating count of cycles with out_valid=0
module pipe_stage_reg #(
    parameter int unsigned NUM_WORDS = 3,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned CTRL_W    = 6,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_WORDS*WORD_W-1:0] in_data,
    input  logic [REG_W-1:0]            in_reg,
    input  logic [CTRL_W-1:0]           in_ctrl,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_WORDS*WORD_W-1:0] out_data,
    output logic [REG_W-1:0]            out_reg,
    output logic [CTRL_W-1:0]           out_ctrl,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            bubble_cnt
);

    localparam int unsigned DataW = NUM_WORDS * WORD_W;
    localparam int unsigned PayW  = DataW + REG_W + CTRL_W;

    // Occupancy encoded as {skid_valid, main_valid}.
    localparam logic [1:0] StEmpty = 2'b00;
    localparam logic [1:0] StOne   = 2'b01;
    localparam logic [1:0] StFull  = 2'b11;

    logic [PayW-1:0]  in_pay;
    logic [PayW-1:0]  main_pay_q, main_pay_d;
    logic [PayW-1:0]  skid_pay_q, skid_pay_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             in_fire;
    logic             out_fire;

    assign in_pay = {in_ctrl, in_reg, in_data};

    always_comb begin
        main_pay_d   = main_pay_q;
        skid_pay_d   = skid_pay_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        bubble_cnt_d = bubble_cnt_q;
        in_fire      = in_valid & in_ready_q;
        out_fire     = main_valid_q & out_ready;

        if (flush) begin
            // Squash everything; payload regs keep their contents, only valids drop.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case ({skid_valid_q, main_valid_q})
                StEmpty: begin
                    if (in_fire) begin
                        main_pay_d   = in_pay;
                        main_valid_d = 1'b1;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_pay_d = in_pay;
                    end else if (in_fire) begin
                        skid_pay_d   = in_pay;
                        skid_valid_d = 1'b1;
                    end else if (out_fire) begin
                        main_valid_d = 1'b0;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        main_pay_d   = skid_pay_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end

        // Registered ready: computed from next-state occupancy, never from out_ready directly.
        in_ready_d = ~skid_valid_d;

        if (cnt_clr) begin
            bubble_cnt_d = '0;
        end else if (!main_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_pay_q   <= '0;
            skid_pay_q   <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            bubble_cnt_q <= '0;
        end else begin
            main_pay_q   <= main_pay_d;
            skid_pay_q   <= skid_pay_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign out_data   = main_pay_q[DataW-1:0];
    assign out_reg    = main_pay_q[DataW +: REG_W];
    assign out_ctrl   = main_pay_q[DataW+REG_W +: CTRL_W] & {CTRL_W{main_valid_q}};
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: a FIFO-of-depth-2 reference model with a
// scoreboard queue; a negedge monitor pops and compares on every out_fire.
module tb_pipe_stage_reg;

    localparam int unsigned CNT_W = 4;
    localparam int         CMAX  = 15;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic [4:0]  in_reg;
    logic [5:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic [4:0]  out_reg;
    logic [5:0]  out_ctrl;
    logic        cnt_clr;
    logic [3:0]  bubble_cnt;

    typedef struct {
        logic [95:0] d;
        logic [4:0]  r;
        logic [5:0]  c;
    } item_t;

    item_t sb[$];
    item_t mon_it;
    int    occ;        // items held by the stage (0..2)
    int    cnt;        // expected bubble counter
    bit    last_fire;  // model: last step accepted its input
    int    n_vec;
    int    n_fail;

    pipe_stage_reg #(
        .NUM_WORDS(3),
        .WORD_W   (32),
        .REG_W    (5),
        .CTRL_W   (6),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_reg    (in_reg),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_reg   (out_reg),
        .out_ctrl  (out_ctrl),
        .cnt_clr   (cnt_clr),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, then advance the reference model at the edge.
    task automatic step(input bit v, input logic [95:0] d, input logic [4:0] r,
                        input logic [5:0] c, input bit ordy, input bit fl, input bit clr);
        bit fire_in;
        bit fire_out;
        item_t it;
        in_valid  = v;
        in_data   = d;
        in_reg    = r;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        @(posedge clk);
        fire_in  = v && (occ < 2);
        fire_out = (occ > 0) && ordy;
        if (rst_n) begin
            if (clr) cnt = 0;
            else if (occ == 0 && cnt < CMAX) cnt++;
            if (fl) begin
                occ = 0;
                sb.delete();
                fire_in = 1'b0;
            end else begin
                occ = occ + int'(fire_in) - int'(fire_out);
                if (fire_in) begin
                    it.d = d;
                    it.r = r;
                    it.c = c;
                    sb.push_back(it);
                end
            end
        end
        last_fire = fire_in;
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 96'h0, 5'h0, 6'h0, ordy, 1'b0, 1'b0);
    endtask

    // Monitor: inputs settle 1 time unit after posedge, so negedge sees stable handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", {127'h0, out_valid}, {127'h0, (occ > 0)});
            chk("in_ready", {127'h0, in_ready}, {127'h0, (occ < 2)});
            chk("bubble_cnt", {124'h0, bubble_cnt}, 128'(cnt));
            if (!out_valid) chk("ctrl_gated", {122'h0, out_ctrl}, 128'h0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL sb_underflow: got unexpected output %0h expected none",
                             out_data);
                end else begin
                    mon_it = sb.pop_front();
                    chk("out_data", {32'h0, out_data}, {32'h0, mon_it.d});
                    chk("out_reg", {123'h0, out_reg}, {123'h0, mon_it.r});
                    chk("out_ctrl", {122'h0, out_ctrl}, {122'h0, mon_it.c});
                end
            end
        end
    end

    initial begin
        logic [95:0] da, db, dc, dd, dx;
        int          tries;
        n_vec = 0;
        n_fail = 0;
        occ = 0;
        cnt = 0;
        last_fire = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_reg = '0;
        in_ctrl = '0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        #12;
        chk("rst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("rst_in_ready", {127'h0, in_ready}, 128'h1);
        chk("rst_out_ctrl", {122'h0, out_ctrl}, 128'h0);
        chk("rst_out_data", {32'h0, out_data}, 128'h0);
        chk("rst_out_reg", {123'h0, out_reg}, 128'h0);
        chk("rst_bubble", {124'h0, bubble_cnt}, 128'h0);
        rst_n = 1'b1;

        // Full-throughput stream.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, {32'h3, 32'h2, 32'h1}, 5'd5, 6'b000100, 1'b1, 1'b0, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // Back-pressure: A, B fill the stage; C must wait.
        da = {32'hA2, 32'hA1, 32'hA0};
        db = {32'hB2, 32'hB1, 32'hB0};
        dc = {32'hC2, 32'hC1, 32'hC0};
        step(1'b1, da, 5'd1, 6'b000001, 1'b0, 1'b0, 1'b0);
        step(1'b1, db, 5'd2, 6'b000010, 1'b0, 1'b0, 1'b0);
        step(1'b1, dc, 5'd3, 6'b000011, 1'b0, 1'b0, 1'b0);
        step(1'b1, dc, 5'd3, 6'b000011, 1'b0, 1'b0, 1'b0);
        tries = 0;
        do begin
            step(1'b1, dc, 5'd3, 6'b000011, 1'b1, 1'b0, 1'b0);
            tries++;
        end while (!last_fire && tries < 5);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Flush while full with D offered.
        dd = {32'hD2, 32'hD1, 32'hD0};
        step(1'b1, da, 5'd1, 6'b000101, 1'b0, 1'b0, 1'b0);
        step(1'b1, db, 5'd2, 6'b000110, 1'b0, 1'b0, 1'b0);
        step(1'b1, dd, 5'd4, 6'b111000, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Bubble gating: data stays, ctrl goes to zero.
        dx = {32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
        step(1'b1, dx, 5'd31, 6'b111111, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        chk("gate_valid", {127'h0, out_valid}, 128'h0);
        chk("gate_ctrl", {122'h0, out_ctrl}, 128'h0);
        chk("gate_data_hold", {32'h0, out_data}, {32'h0, dx});
        chk("gate_reg_hold", {123'h0, out_reg}, 128'd31);

        // Counter saturation and clear.
        for (int i = 0; i < 20; i++) idle(1'b0);
        chk("cnt_sat", {124'h0, bubble_cnt}, 128'd15);
        step(1'b0, 96'h0, 5'h0, 6'h0, 1'b0, 1'b0, 1'b1);
        chk("cnt_clr", {124'h0, bubble_cnt}, 128'd0);
        idle(1'b0);
        chk("cnt_resume", {124'h0, bubble_cnt}, 128'd1);

        // Async reset while full, between edges.
        step(1'b1, da, 5'd7, 6'b001111, 1'b0, 1'b0, 1'b0);
        step(1'b1, db, 5'd8, 6'b110000, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {127'h0, out_valid}, 128'h0);
        chk("arst_in_ready", {127'h0, in_ready}, 128'h1);
        chk("arst_out_ctrl", {122'h0, out_ctrl}, 128'h0);
        chk("arst_out_data", {32'h0, out_data}, 128'h0);
        chk("arst_bubble", {124'h0, bubble_cnt}, 128'h0);
        occ = 0;
        cnt = 0;
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 70,
                 {$urandom, $urandom, $urandom},
                 5'($urandom), 6'($urandom),
                 $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 5);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("sb_drained", 128'(sb.size()), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the pipelined RISC datapath. It generalises the fixed MEM/WB-style flop bank into a configurable payload with a valid/ready handshake, a 2-entry skid buffer for back-pressure, and synchronous flush. Control bits are forced to zero when the stage holds a bubble. A saturating bubble counter feeds the performance counters. One instance sits between each pair of pipeline stages.

Parameters:
NUM_WORDS, 3, number of WORD_W data fields in the payload (e.g. pc+4, alu result, read data)
WORD_W, 32, width of each data field
REG_W, 5, destination register index width
CTRL_W, 6, control bit count (memwrite, memread, wr_en, memtoreg, jump, pcsrc)
CNT_W, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept (registered)
in_data  in  NUM_WORDS*WORD_W  packed data fields, word 0 in LSBs
in_reg  in  REG_W  destination register index
in_ctrl  in  CTRL_W  control bits
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts
out_data  out  NUM_WORDS*WORD_W  registered data
out_reg  out  REG_W  registered destination index
out_ctrl  out  CTRL_W  registered control, zero when out_valid=0
cnt_clr  in  1  synchronous clear of bubble counter
bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating

Behaviour:
- Reset (rst_n=0, async): main/skid valid=0, all payload regs=0, bubble_cnt=0, in_ready=1, out_valid=0, out_ctrl=0.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry. States by valid bits: EMPTY (none), ONE (main), FULL (main+skid).
- EMPTY: in_fire -> ONE, main<=in.
- ONE: in_fire&out_fire -> ONE, main<=in; in_fire&!out_fire -> FULL, skid<=in; !in_fire&out_fire -> EMPTY; else hold.
- FULL: in_ready=0 so no in_fire; out_fire -> ONE, main<=skid; else hold.
- Latency: payload accepted at edge N appears on outputs after edge N (1 cycle); full throughput 1/cycle when out_ready=1.
- in_ready = !skid_valid, driven from a flop; no combinational path out_ready->in_ready.
- in_valid with in_ready=0: ignored, not captured; upstream must hold payload.
- flush=1: highest priority; next state EMPTY, both valids cleared, same-cycle in_fire discarded, same-cycle out_fire still counts as consumed downstream. Payload regs are not cleared; out_ctrl is gated to 0 by out_valid.
- out_ctrl = main_ctrl & {CTRL_W{out_valid}}. out_data/out_reg show last main contents regardless of valid.
- bubble_cnt: +1 every cycle out_valid=0 (registered state), saturates at 2^CNT_W-1; cnt_clr=1 sets 0 that cycle (clear beats increment).
- Reset asserted mid-operation: all entries dropped immediately; no payload survives.

Test Plan:
- Reset then stream: in_data={0x3,0x2,0x1}, in_reg=5, in_ctrl=6'b000100, out_ready=1 -> next cycle out_valid=1, out_data/out_reg/out_ctrl match; 1 item/cycle for 8 consecutive items, in_ready stays 1.
- Back-pressure: out_ready=0, push A then B -> A held on outputs, B in skid, in_ready=0 from the cycle after B; C offered is not taken; out_ready=1 -> A, B, C delivered in order, none lost or duplicated.
- Flush while FULL with in_valid=1 (item D) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, D never appears.
- Bubble gating: main_ctrl=6'b111111, out_fire with no new input -> out_valid=0, out_ctrl=0, out_data unchanged.
- Counter: CNT_W=4, idle 20 cycles -> bubble_cnt saturates at 15; cnt_clr pulse -> 0 then resumes counting.
- Async reset asserted between clock edges while FULL -> outputs and valids go to 0 immediately, before the next clk edge.
